// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle controller.
// Holds the per-channel FSM state encoding and the default
// playfield geometry used as parameter defaults.
package paddle_pkg;

    localparam int unsigned Y_W       = 11;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned BAT_SMALL = 48;
    localparam int unsigned BAT_LARGE = 96;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2
    } paddle_state_e;

endpackage

// File: rtl/paddle_channel.sv
// One paddle channel: direction decode (buttons or AI), motion FSM,
// hold-to-accelerate speed/run counters and playfield clamp.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   tick          update strobe; all inputs are only looked at when high
//   up, down      button inputs (ignored when ai_en=1)
//   ai_en         1 = track ball_y instead of buttons
//   ball_y        ball top Y
//   bat_h         current paddle height
//   p_y           registered paddle top Y
//   moving        registered: position changed on the last tick
module paddle_channel
    import paddle_pkg::*;
#(
    parameter int unsigned Y_W         = paddle_pkg::Y_W,
    parameter int unsigned SCREEN_H    = paddle_pkg::SCREEN_H,
    parameter int unsigned STEP_MIN    = 1,
    parameter int unsigned STEP_MAX    = 8,
    parameter int unsigned ACCEL_TICKS = 8,
    parameter int unsigned AI_DEAD     = 4,
    parameter int unsigned Y_RESET     = 216
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick,
    input  logic           up,
    input  logic           down,
    input  logic           ai_en,
    input  logic [Y_W-1:0] ball_y,
    input  logic [Y_W-1:0] bat_h,
    output logic [Y_W-1:0] p_y,
    output logic           moving
);

    localparam int unsigned SW    = Y_W + 1;
    localparam int unsigned SPD_W = $clog2(STEP_MAX + 1);
    localparam int unsigned RUN_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

    paddle_state_e     state, state_next;
    logic [SPD_W-1:0]  speed, speed_next;
    logic [RUN_W-1:0]  run, run_next;
    logic [Y_W-1:0]    py_next;
    logic              moving_next;
    logic [SW-1:0]     centre;
    logic [SW-1:0]     ball_ext;
    logic signed [SW-1:0] pos;
    logic signed [SW-1:0] limit;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            speed  <= SPD_W'(STEP_MIN);
            run    <= '0;
            p_y    <= Y_W'(Y_RESET);
            moving <= 1'b0;
        end else begin
            state  <= state_next;
            speed  <= speed_next;
            run    <= run_next;
            p_y    <= py_next;
            moving <= moving_next;
        end
    end

    // Direction decode: the FSM simply follows the sampled direction
    always_comb begin
        state_next = state;
        centre     = {1'b0, p_y} + {1'b0, (bat_h >> 1)};
        ball_ext   = {1'b0, ball_y};
        if (tick) begin
            state_next = ST_IDLE;
            if (ai_en) begin
                if ((ball_ext + SW'(AI_DEAD)) < centre) begin
                    state_next = ST_MOVE_UP;
                end else if (ball_ext > (centre + SW'(AI_DEAD))) begin
                    state_next = ST_MOVE_DOWN;
                end
            end else if (up && !down) begin
                state_next = ST_MOVE_UP;
            end else if (down && !up) begin
                state_next = ST_MOVE_DOWN;
            end
        end
    end

    // Speed/run update, signed position step and clamp
    always_comb begin
        speed_next  = speed;
        run_next    = run;
        py_next     = p_y;
        moving_next = moving;
        pos         = signed'({1'b0, p_y});
        limit       = signed'(SW'(SCREEN_H) - {1'b0, bat_h});
        if (tick) begin
            if (state_next == ST_IDLE || state_next != state) begin
                speed_next = SPD_W'(STEP_MIN);
                run_next   = '0;
            end else if (run == RUN_W'(ACCEL_TICKS - 1)) begin
                run_next = '0;
                if (speed != SPD_W'(STEP_MAX)) begin
                    speed_next = speed + SPD_W'(1);
                end
            end else begin
                run_next = run + RUN_W'(1);
            end

            // New speed applies to the step taken on this same tick
            case (state_next)
                ST_MOVE_UP:   pos = pos - signed'(SW'(speed_next));
                ST_MOVE_DOWN: pos = pos + signed'(SW'(speed_next));
                default:      pos = pos;
            endcase

            // Clamp every tick so a bat size change pulls the paddle back in
            if (pos[SW-1]) begin
                pos = '0;
            end else if (pos > limit) begin
                pos = limit;
            end

            py_next     = pos[Y_W-1:0];
            moving_next = (py_next != p_y);
        end
    end

endmodule

// File: rtl/paddle_ctrl_multi.sv
// N-paddle position controller. Generates the update tick, selects
// the shared bat height and packs the per-channel paddle positions.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   up, down   per-channel debounced buttons
//   ai_en      per-channel AI select
//   bat_size   0 = BAT_SMALL, 1 = BAT_LARGE
//   ball_y     ball top Y for AI channels
//   p_y        packed paddle top Y, channel i at [i*Y_W +: Y_W]
//   moving     per-channel moved-on-last-tick flag
//   tick       single-cycle update strobe
module paddle_ctrl_multi
    import paddle_pkg::*;
#(
    parameter int unsigned N_PADDLES   = 2,
    parameter int unsigned Y_W         = paddle_pkg::Y_W,
    parameter int unsigned SCREEN_H    = paddle_pkg::SCREEN_H,
    parameter int unsigned BAT_SMALL   = paddle_pkg::BAT_SMALL,
    parameter int unsigned BAT_LARGE   = paddle_pkg::BAT_LARGE,
    parameter int unsigned STEP_MIN    = 1,
    parameter int unsigned STEP_MAX    = 8,
    parameter int unsigned ACCEL_TICKS = 8,
    parameter int unsigned TICK_DIV    = 416667,
    parameter int unsigned AI_DEAD     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PADDLES-1:0]     up,
    input  logic [N_PADDLES-1:0]     down,
    input  logic [N_PADDLES-1:0]     ai_en,
    input  logic                     bat_size,
    input  logic [Y_W-1:0]           ball_y,
    output logic [N_PADDLES*Y_W-1:0] p_y,
    output logic [N_PADDLES-1:0]     moving,
    output logic                     tick
);

    localparam int unsigned CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned Y_RESET = (SCREEN_H - BAT_SMALL) / 2;

    logic [CNT_W-1:0] tick_cnt;
    logic [Y_W-1:0]   bat_h;

    // Tick divider; tick is registered one count early so it is high
    // exactly while the counter sits at TICK_DIV-1
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            if (tick_cnt == CNT_W'(TICK_DIV - 1)) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
            tick <= (tick_cnt == CNT_W'(TICK_DIV - 2));
        end
    end

    assign bat_h = bat_size ? Y_W'(BAT_LARGE) : Y_W'(BAT_SMALL);

    for (genvar i = 0; i < N_PADDLES; i++) begin : g_ch
        paddle_channel #(
            .Y_W         (Y_W),
            .SCREEN_H    (SCREEN_H),
            .STEP_MIN    (STEP_MIN),
            .STEP_MAX    (STEP_MAX),
            .ACCEL_TICKS (ACCEL_TICKS),
            .AI_DEAD     (AI_DEAD),
            .Y_RESET     (Y_RESET)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .up     (up[i]),
            .down   (down[i]),
            .ai_en  (ai_en[i]),
            .ball_y (ball_y),
            .bat_h  (bat_h),
            .p_y    (p_y[i*Y_W +: Y_W]),
            .moving (moving[i])
        );
    end

endmodule

// File: tb/tb_paddle_ctrl_multi.sv
// Directed self-checking bench for paddle_ctrl_multi (TICK_DIV=4).
module tb_paddle_ctrl_multi;

    logic        clk;
    logic        rst;
    logic [1:0]  up;
    logic [1:0]  down;
    logic [1:0]  ai_en;
    logic        bat_size;
    logic [10:0] ball_y;
    logic [21:0] p_y;
    logic [1:0]  moving;
    logic        tick;

    int n_asserts = 0;
    int n_fail    = 0;

    paddle_ctrl_multi #(
        .TICK_DIV (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .up       (up),
        .down     (down),
        .ai_en    (ai_en),
        .bat_size (bat_size),
        .ball_y   (ball_y),
        .p_y      (p_y),
        .moving   (moving),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] py(input int ch);
        return 32'(p_y[ch*11 +: 11]);
    endfunction

    // Advance until the current cycle is a tick cycle (bounded)
    task automatic wait_tick();
        int b = 0;
        while (tick !== 1'b1 && b < 20) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (tick !== 1'b1) check("tick_timeout", 32'(tick), 32'd1);
    endtask

    // Let one tick be applied, then sample one cycle after it
    task automatic run_tick();
        wait_tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp0;
        int exp1;
        int nxt;
        int spd;
        int k;

        rst = 1'b1; up = '0; down = '0; ai_en = '0; bat_size = 1'b0; ball_y = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_py0", py(0), 216);
        check("rst_py1", py(1), 216);
        check("rst_moving", 32'(moving), 0);
        check("rst_tick", 32'(tick), 0);
        rst = 1'b0;
        @(posedge clk); #1; check("tick_cyc2", 32'(tick), 0);
        @(posedge clk); #1; check("tick_cyc3", 32'(tick), 0);
        @(posedge clk); #1; check("tick_cyc4", 32'(tick), 1);

        // Hold up on ch0 for 20 ticks: steps 1x8, 2x8, 3x4
        up = 2'b01;
        exp0 = 216;
        for (int i = 0; i < 20; i++) begin
            run_tick();
            exp0 -= (i < 8) ? 1 : ((i < 16) ? 2 : 3);
            check($sformatf("up_py0_t%0d", i), py(0), exp0);
            check($sformatf("up_mv0_t%0d", i), 32'(moving[0]), 1);
        end
        check("up_final_py0", py(0), 180);
        check("up_py1_still", py(1), 216);
        check("up_mv1_still", 32'(moving[1]), 0);
        up = 2'b00;
        run_tick();
        check("rel_py0", py(0), 180);
        check("rel_mv0", 32'(moving[0]), 0);
        up = 2'b01;
        run_tick();
        check("repress_py0", py(0), 179);
        check("repress_mv0", 32'(moving[0]), 1);
        up = 2'b00;
        run_tick();
        check("idle_py0", py(0), 179);

        // Hold down on ch1 into the bottom wall
        down = 2'b10;
        exp1 = 216;
        for (int i = 0; i < 60; i++) begin
            run_tick();
            spd = 1 + i / 8;
            if (spd > 8) spd = 8;
            nxt = exp1 + spd;
            if (nxt > 432) nxt = 432;
            check($sformatf("dn_mv1_t%0d", i), 32'(moving[1]), 32'(nxt != exp1));
            exp1 = nxt;
            check($sformatf("dn_py1_t%0d", i), py(1), exp1);
        end
        check("dn_wall_py1", py(1), 432);
        check("dn_wall_mv1", 32'(moving[1]), 0);
        bat_size = 1'b1;
        run_tick();
        check("large_py1", py(1), 384);
        check("large_mv1", 32'(moving[1]), 1);
        check("large_py0", py(0), 179);
        down = 2'b00;
        bat_size = 1'b0;
        run_tick();
        check("small_py1", py(1), 384);
        check("small_mv1", 32'(moving[1]), 0);

        // Both buttons: no motion, speed reset
        up = 2'b01;
        repeat (9) run_tick();
        check("pre_both_py0", py(0), 169);
        down = 2'b01;
        run_tick();
        check("both_py0", py(0), 169);
        check("both_mv0", 32'(moving[0]), 0);
        down = 2'b00;
        run_tick();
        check("after_both_py0", py(0), 168);
        up = 2'b00;
        run_tick();

        // Reset landing on a tick cycle at speed 5
        up = 2'b01;
        repeat (33) run_tick();
        check("pre_rst_py0", py(0), 83);
        wait_tick();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("tickrst_py0", py(0), 216);
        check("tickrst_py1", py(1), 216);
        check("tickrst_moving", 32'(moving), 0);
        check("tickrst_tick", 32'(tick), 0);
        rst = 1'b0;
        run_tick();
        check("post_rst_py0", py(0), 215);
        check("post_rst_mv0", 32'(moving[0]), 1);
        up = 2'b00;
        run_tick();
        check("post_rst_idle_py0", py(0), 215);

        // AI on ch1 tracking ball_y=100; buttons on ch1 ignored
        ai_en  = 2'b10;
        down   = 2'b10;
        ball_y = 11'd100;
        exp1 = 216;
        k = 0;
        for (int i = 0; i < 46; i++) begin
            run_tick();
            if (100 + 4 < exp1 + 24) begin
                spd = 1 + k / 8;
                if (spd > 8) spd = 8;
                nxt = exp1 - spd;
                if (nxt < 0) nxt = 0;
                k++;
            end else begin
                nxt = exp1;
                k = 0;
            end
            check($sformatf("ai_mv1_t%0d", i), 32'(moving[1]), 32'(nxt != exp1));
            exp1 = nxt;
            check($sformatf("ai_py1_t%0d", i), py(1), exp1);
        end
        check("ai_final_py1", py(1), 78);
        check("ai_final_mv1", 32'(moving[1]), 0);
        check("ai_py0_untouched", py(0), 215);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl_multi.md
# paddle_ctrl_multi

Parametrised paddle-position controller for the ball-and-paddle game, generalising the two-player button controller to N paddles. Each paddle is driven either by debounced up/down buttons or by a built-in ball-tracking AI, and moves with hold-to-accelerate speed on a fixed frame-rate tick. The block feeds paddle Y positions to the game controller and video encoder and clamps every paddle to the playfield for the selected bat size.

## Interface
- N_PADDLES, 2, number of independent paddle channels
- Y_W, 11, coordinate width (matches game coordinate buses)
- SCREEN_H, 480, playfield height in pixels
- BAT_SMALL, 48, paddle height when bat_size=0
- BAT_LARGE, 96, paddle height when bat_size=1
- STEP_MIN, 1, pixels per tick at start of motion
- STEP_MAX, 8, pixels-per-tick ceiling
- ACCEL_TICKS, 8, consecutive same-direction ticks per +1 speed
- TICK_DIV, 416667, clk cycles per update tick (120 Hz at 50 MHz)
- AI_DEAD, 4, AI deadband in pixels around paddle centre
---
- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- up  in  N_PADDLES  debounced "move up" (decreasing Y), active-high
- down  in  N_PADDLES  debounced "move down" (increasing Y), active-high
- ai_en  in  N_PADDLES  1 = channel driven by AI, buttons ignored
- bat_size  in  1  0 = BAT_SMALL, 1 = BAT_LARGE (shared by all paddles)
- ball_y  in  Y_W  ball top Y, used by AI channels
- p_y  out  N_PADDLES*Y_W  paddle top Y, channel i at bits [i*Y_W +: Y_W]
- moving  out  N_PADDLES  1 = channel moved on the last tick
- tick  out  1  single-cycle update strobe (for downstream frame logic)

## Operation
- Tick counter counts 0..TICK_DIV-1; tick=1 for exactly the cycle the counter equals TICK_DIV-1, then wraps to 0.
- Inputs up/down/ai_en/ball_y/bat_size are sampled only on tick cycles; values between ticks are ignored.
- Per channel, direction on tick: ai_en=1 -> centre = p_y + bat_h/2; UP if ball_y + AI_DEAD < centre, DOWN if ball_y > centre + AI_DEAD, else IDLE. ai_en=0 -> UP if up&~down, DOWN if down&~up, else IDLE (both pressed = IDLE).
- Per-channel FSM states IDLE, MOVE_UP, MOVE_DOWN; state follows the sampled direction each tick.
- Speed register (range STEP_MIN..STEP_MAX) and run counter (0..ACCEL_TICKS-1): on entry to a MOVE state from any other state speed=STEP_MIN, run=0; staying in the same MOVE state run increments, and when run wraps from ACCEL_TICKS-1 to 0, speed increments, saturating at STEP_MAX. IDLE resets speed=STEP_MIN, run=0.
- Position update uses Y_W+1-bit signed arithmetic: MOVE_UP new = p_y - speed, MOVE_DOWN new = p_y + speed, IDLE new = p_y. Result clamped to [0, SCREEN_H - bat_h]; no wrap-around ever.
- Clamp applied on every tick, including IDLE, so a bat_size 0->1 change pulls a low paddle up to SCREEN_H-BAT_LARGE on the next tick.
- moving = 1 iff the clamped new value differs from the old p_y (pinned at a wall while pressing gives moving=0, but speed still accelerates).
- Switching ai_en mid-motion: treated as normal direction evaluation; a direction change resets speed.

## Timing
- Reset values: tick counter 0, tick=0, every p_y = (SCREEN_H-BAT_SMALL)/2 = 216, moving=0, all FSMs IDLE, speed=STEP_MIN, run=0.
- p_y, moving, speed and state register on the clock edge ending the tick cycle: new values visible the cycle after tick=1 (latency 1).
- First tick after reset occurs TICK_DIV cycles after rst deasserts.
- rst asserted mid-operation overrides everything on the next edge, including a coincident tick.
- All outputs registered; no combinational input-to-output path.

## Structure
- Package paddle_pkg: FSM state encoding (IDLE/MOVE_UP/MOVE_DOWN), default geometry constants (SCREEN_H, BAT_SMALL, BAT_LARGE), Y_W.
- Sub-module paddle_channel: one channel (direction decode, FSM, speed/run counters, clamp), instantiated N_PADDLES times via generate; the top holds the tick counter, bat_h mux and output packing.

## Test plan
(Bench uses TICK_DIV=4, defaults otherwise.)
- Reset: hold rst 3 cycles -> p_y all 216, moving=0, tick first asserts on the 4th cycle after release.
- Hold up on ch0 for 20 ticks -> per-tick decrements 1×8, 2×8, 3×4; p_y = 216-36 = 180; release -> next press steps by 1 again.
- Hold down on ch1 from 216 with bat_size=0 -> p_y saturates at 432, moving drops to 0, never exceeds 432; bat_size=1 -> next tick p_y=384.
- up&down both high on ch0 -> p_y unchanged, moving=0, speed reset.
- ai_en[1]=1, ball_y=100, p_y=216 (centre 240) -> paddle moves up each tick until centre within 96..104, then holds with moving=0.
- rst asserted on a tick cycle while ch0 moving at speed 5 -> next cycle p_y=216, speed=STEP_MIN, no movement applied.
